hall_event_filter: RTL and testbench
====================================

// Module: hall_event_filter
// PURPOSE
//   Conditions the raw hall-sensor input ahead of the control core: synchronises, debounces and
//   edge-detects magnet passes, then emits a one-cycle event pulse, a saturating event count,
//   the interval (ms) between consecutive events, and a stall flag when no magnet is seen for too long.
//   Sits between the hall pin and Core, replacing direct use of the raw hall level.
// PARAMETERS
//   CLK_PER_US   50    clk cycles per microsecond tick (50 MHz crystal)
//   DEBOUNCE_US  2000  consecutive stable microseconds required to accept a level change
//   STALL_MS     1000  ms without an event before stall asserts
//   ACTIVE_LOW   1     1: magnet present when hall==0; 0: present when hall==1
//   CNT_W        8     width of event counter
//   PERIOD_W     16    width of interval measurement (ms)
// PORTS
//   clk           in   1         50 MHz system clock
//   rst           in   1         synchronous reset, active-low
//   hall          in   1         raw asynchronous hall-sensor level
//   enable        in   1         1: events counted/timed; 0: filter tracks level only
//   clear         in   1         1-cycle: zero count, period, period_valid, elapsed timer
//   present       out  1         debounced magnet-present level
//   event         out  1         1-cycle pulse on accepted magnet arrival
//   count         out  CNT_W     accepted events since reset/clear, saturating
//   period_ms     out  PERIOD_W  ms between last two events, saturating
//   period_valid  out  1         period_ms holds a real interval
//   stall         out  1         enable high and no event for >= STALL_MS
// BEHAVIOUR
//   - Reset (rst==0 at posedge): all outputs 0, FSM ABSENT, prescalers/timers 0. Reset mid-debounce
//     discards the partial debounce; synchroniser flops also cleared.
//   - Input path: 2-flop synchroniser, then polarity normalised per ACTIVE_LOW to signal mag.
//   - Timebase: us_tick every CLK_PER_US clk (counter 0..CLK_PER_US-1); ms_tick every 1000 us_ticks.
//   - Debounce FSM (db counter counts us_ticks, cleared on every state change):
//       ABSENT  : mag==1 -> ARMING.
//       ARMING  : mag==0 -> ABSENT; db reaches DEBOUNCE_US -> PRESENT.
//       PRESENT : mag==0 -> RELEASE.
//       RELEASE : mag==1 -> PRESENT; db reaches DEBOUNCE_US -> ABSENT.
//     present = 1 in PRESENT and RELEASE. Glitch shorter than DEBOUNCE_US: no output change.
//   - event = 1 for exactly the cycle after ARMING->PRESENT, only if enable==1. Latency from hall edge:
//     2 sync cycles + DEBOUNCE_US*CLK_PER_US (+<1 us tick phase). Release produces no event.
//   - count: +1 on event; holds at 2^CNT_W-1. clear and event same cycle -> count=1.
//   - elapsed (PERIOD_W, ms): +1 per ms_tick, saturates all-ones. On event: period_ms<=elapsed,
//     elapsed<=0, period_valid<=1 only if a prior event exists since reset/clear (first event: elapsed
//     reset, period_valid stays 0). clear and event same cycle: treated as first event after clear.
//   - enable==0: elapsed held at 0, no events, count/period held, stall=0. FSM keeps tracking; a magnet
//     already PRESENT when enable rises is not counted.
//   - stall: set when enable==1 and elapsed >= STALL_MS; cleared on next event, clear, or enable==0.
//   - Magnet present through reset release: ARMING then event after debounce if enable==1.
//   - All outputs registered; no combinational path hall->outputs.
// TESTING
//   (Use DEBOUNCE_US=20, STALL_MS=5, CLK_PER_US=50 for sim speed.)
//   1 rst low 3 cycles, hall=1 -> all outputs 0; release, hall stays 1 -> no event, present=0.
//   2 hall=0 for 10 us then 1 -> no event, present never 1; hall=0 for 25 us -> single event at
//     ~20 us+2 cycles, present=1, count=1, period_valid=0.
//   3 second pass 3 ms after first -> period_ms=3, period_valid=1, count=2; stall stays 0.
//   4 no pass for 6 ms, enable=1 -> stall=1 at elapsed=5; next pass -> stall=0, period_ms=6+.
//   5 CNT_W=2: five passes -> count 1,2,3,3,3; clear coincident with 6th event -> count=1, period_valid=0.
//   6 enable=0 during a pass -> present toggles, event/count unchanged; rst low mid-ARMING -> ABSENT, no event.

Source files
------------

// File: rtl/hall_event_filter.sv
// Hall-sensor front end: synchronise, debounce and edge-detect magnet passes,
// then report an event pulse, a saturating event count, the interval in ms
// between consecutive events and a stall flag. The event output is named
// event_pulse because "event" is a reserved word in SystemVerilog.
module hall_event_filter #(
    parameter int CLK_PER_US  = 50,
    parameter int DEBOUNCE_US = 2000,
    parameter int STALL_MS    = 1000,
    parameter int ACTIVE_LOW  = 1,
    parameter int CNT_W       = 8,
    parameter int PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hall,
    input  logic                enable,
    input  logic                clear,
    output logic                present,
    output logic                event_pulse,
    output logic [CNT_W-1:0]    count,
    output logic [PERIOD_W-1:0] period_ms,
    output logic                period_valid,
    output logic                stall
);

    localparam int US_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_US + 1);

    typedef enum logic [1:0] {
        ABSENT  = 2'd0,
        ARMING  = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [1:0]          sync_reg;
    logic [US_W-1:0]     us_cnt_reg;
    logic [9:0]          ms_cnt_reg;
    state_t              state_reg;
    logic [DB_W-1:0]     db_reg;
    logic [PERIOD_W-1:0] elapsed_reg;
    logic                have_prior_reg;

    logic mag;
    logic us_tick;
    logic ms_tick;
    logic db_done;
    logic fire;

    assign mag     = (ACTIVE_LOW != 0) ? ~sync_reg[1] : sync_reg[1];
    assign us_tick = (us_cnt_reg == US_W'(CLK_PER_US - 1));
    assign ms_tick = us_tick && (ms_cnt_reg == 10'd999);
    assign db_done = us_tick && (db_reg == DB_W'(DEBOUNCE_US - 1));
    // Accepted arrival: the debounce window closes while still in ARMING.
    assign fire    = (state_reg == ARMING) && mag && db_done && enable;

    // Two-flop synchroniser for the asynchronous hall pin.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], hall};
        end
    end

    // Free-running microsecond and millisecond timebase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            us_cnt_reg <= '0;
            ms_cnt_reg <= '0;
        end else begin
            us_cnt_reg <= us_tick ? '0 : us_cnt_reg + US_W'(1);
            if (ms_tick) begin
                ms_cnt_reg <= '0;
            end else if (us_tick) begin
                ms_cnt_reg <= ms_cnt_reg + 10'd1;
            end
        end
    end

    // Debounce FSM; db counts microsecond ticks and restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ABSENT;
            db_reg    <= '0;
            present   <= 1'b0;
        end else begin
            case (state_reg)
                ABSENT: begin
                    if (mag) begin
                        state_reg <= ARMING;
                        db_reg    <= '0;
                    end
                end
                ARMING: begin
                    if (!mag) begin
                        state_reg <= ABSENT;
                        db_reg    <= '0;
                    end else if (db_done) begin
                        state_reg <= PRESENT;
                        db_reg    <= '0;
                        present   <= 1'b1;
                    end else if (us_tick) begin
                        db_reg <= db_reg + DB_W'(1);
                    end
                end
                PRESENT: begin
                    if (!mag) begin
                        state_reg <= RELEASE;
                        db_reg    <= '0;
                    end
                end
                RELEASE: begin
                    if (mag) begin
                        state_reg <= PRESENT;
                        db_reg    <= '0;
                    end else if (db_done) begin
                        state_reg <= ABSENT;
                        db_reg    <= '0;
                        present   <= 1'b0;
                    end else if (us_tick) begin
                        db_reg <= db_reg + DB_W'(1);
                    end
                end
                default: begin
                    state_reg <= ABSENT;
                    db_reg    <= '0;
                    present   <= 1'b0;
                end
            endcase
        end
    end

    // Event pulse, saturating count and the record of a prior event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            event_pulse    <= 1'b0;
            count          <= '0;
            have_prior_reg <= 1'b0;
        end else begin
            event_pulse <= fire;
            if (clear) begin
                // A coincident event becomes the first event after the clear.
                count          <= fire ? CNT_W'(1) : '0;
                have_prior_reg <= fire;
            end else if (fire) begin
                have_prior_reg <= 1'b1;
                if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    // Interval capture: elapsed ms since the last event, latched into period_ms.
    always_ff @(posedge clk) begin
        if (!rst) begin
            elapsed_reg  <= '0;
            period_ms    <= '0;
            period_valid <= 1'b0;
        end else begin
            if (!enable || clear || fire) begin
                elapsed_reg <= '0;
            end else if (ms_tick && (elapsed_reg != '1)) begin
                elapsed_reg <= elapsed_reg + PERIOD_W'(1);
            end
            if (clear) begin
                period_ms    <= '0;
                period_valid <= 1'b0;
            end else if (fire && have_prior_reg) begin
                period_ms    <= elapsed_reg;
                period_valid <= 1'b1;
            end
        end
    end

    // Stall flag: too long without an event while enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall <= 1'b0;
        end else if (!enable || clear || fire) begin
            stall <= 1'b0;
        end else if (elapsed_reg >= PERIOD_W'(STALL_MS)) begin
            stall <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hall_event_filter.sv
// Directed bench for hall_event_filter. The main instance runs with one clk
// per microsecond so millisecond intervals fit a short run and latencies are
// exact; a second instance with four clks per microsecond checks the prescaler.
module tb_hall_event_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b0;
    logic hall   = 1'b1;
    logic enable = 1'b1;
    logic clear  = 1'b0;

    logic       present, event_pulse, period_valid, stall;
    logic [1:0] count;
    logic [7:0] period_ms;

    logic        s_present, s_event, s_period_valid, s_stall;
    logic [7:0]  s_count;
    logic [15:0] s_period_ms;

    hall_event_filter #(
        .CLK_PER_US(1), .DEBOUNCE_US(20), .STALL_MS(5),
        .ACTIVE_LOW(1), .CNT_W(2), .PERIOD_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .hall(hall), .enable(enable), .clear(clear),
        .present(present), .event_pulse(event_pulse), .count(count),
        .period_ms(period_ms), .period_valid(period_valid), .stall(stall)
    );

    hall_event_filter #(
        .CLK_PER_US(4), .DEBOUNCE_US(20), .STALL_MS(5),
        .ACTIVE_LOW(1), .CNT_W(8), .PERIOD_W(16)
    ) u_slow (
        .clk(clk), .rst(rst), .hall(hall), .enable(enable), .clear(clear),
        .present(s_present), .event_pulse(s_event), .count(s_count),
        .period_ms(s_period_ms), .period_valid(s_period_valid), .stall(s_stall)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ev_n        = 0;
    int ev_cyc      = 0;
    int s_ev_n      = 0;
    int s_ev_cyc    = 0;
    bit pres_seen   = 1'b0;
    int t0, t1, t3;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};

    // Advance n falling edges, logging event pulses and present levels.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (event_pulse === 1'b1) begin
                ev_n++;
                ev_cyc = cyc;
            end
            if (present === 1'b1) pres_seen = 1'b1;
            if (s_event === 1'b1) begin
                s_ev_n++;
                s_ev_cyc = cyc;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with magnet absent
        run(3);
        chk("rst_present", present, 0);
        chk("rst_event", event_pulse, 0);
        chk("rst_count", count, 0);
        chk("rst_period", period_ms, 0);
        chk("rst_pvalid", period_valid, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b1;
        ev_n = 0; pres_seen = 1'b0;
        run(30);
        chk("idle_no_event", ev_n, 0);
        chk("idle_present", present, 0);

        // 2: 10 us glitch rejected, 25 us pass accepted
        hall = 1'b0; run(10); hall = 1'b1; run(40);
        chk("glitch_event", ev_n, 0);
        chk("glitch_present", pres_seen, 0);
        t0 = cyc;
        hall = 1'b0; run(25); hall = 1'b1;
        chk("pass1_event", ev_n, 1);
        chk("pass1_latency", ev_cyc - t0, 23);
        chk("pass1_present", present, 1);
        chk("pass1_count", count, 1);
        chk("pass1_pvalid", period_valid, 0);
        run(40);
        chk("release_present", present, 0);
        chk("release_no_event", ev_n, 1);

        // 3: second pass 3001 cycles (just over 3 ms) after the first
        run(3001 - 65);
        t1 = cyc;
        hall = 1'b0; run(25); hall = 1'b1;
        chk("pass2_latency", ev_cyc - t1, 23);
        chk("pass2_count", count, 2);
        chk("pass2_period", period_ms, 3);
        chk("pass2_pvalid", period_valid, 1);
        chk("pass2_stall", stall, 0);
        run(40);

        // 4: long gap raises stall, next pass clears it
        run(4022 - 65);
        chk("stall_early", stall, 0);
        run(6501 - 4022);
        chk("stall_set", stall, 1);
        hall = 1'b0; run(25); hall = 1'b1;
        chk("pass3_stall", stall, 0);
        chk("pass3_count", count, 3);
        chk("pass3_period_6_7", (period_ms >= 8'd6 && period_ms <= 8'd7), 1);
        chk("pass3_pvalid", period_valid, 1);
        run(40);

        // 5: clear, saturation at 3, clear coincident with an event
        clear = 1'b1; run(1); clear = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_period", period_ms, 0);
        chk("clear_pvalid", period_valid, 0);
        for (int p = 0; p < 5; p++) begin
            hall = 1'b0; run(25); hall = 1'b1; run(40);
            chk($sformatf("sat_count_%0d", p), count, exp_cnt[p]);
            chk($sformatf("sat_pvalid_%0d", p), period_valid, (p > 0) ? 1 : 0);
        end
        ev_n = 0;
        hall = 1'b0; run(22); clear = 1'b1; run(1); clear = 1'b0;
        chk("coinc_event", ev_n, 1);
        chk("coinc_count", count, 1);
        chk("coinc_pvalid", period_valid, 0);
        run(2); hall = 1'b1; run(40);
        chk("coinc_count_hold", count, 1);

        // 6: disabled pass, magnet present when enable rises, reset mid-ARMING
        enable = 1'b0; ev_n = 0;
        hall = 1'b0; run(25);
        chk("dis_present", present, 1);
        hall = 1'b1; run(40);
        chk("dis_present_off", present, 0);
        chk("dis_event", ev_n, 0);
        chk("dis_count", count, 1);
        chk("dis_stall", stall, 0);
        hall = 1'b0; run(25);
        enable = 1'b1; run(10);
        chk("late_enable_event", ev_n, 0);
        chk("late_enable_count", count, 1);
        hall = 1'b1; run(40);
        hall = 1'b0; run(15);
        rst = 1'b0; run(2); rst = 1'b1;
        run(15);
        chk("rst_arm_event", ev_n, 0);
        chk("rst_arm_count", count, 0);
        chk("rst_arm_present", present, 0);
        run(20);
        chk("through_rst_event", ev_n, 1);
        chk("through_rst_count", count, 1);
        hall = 1'b1; run(40);

        // 7: prescaled instance, debounce spans 20 us of 4 clks each
        run(100);
        s_ev_n = 0; t3 = cyc;
        hall = 1'b0; run(110); hall = 1'b1;
        chk("slow_event", s_ev_n, 1);
        chk("slow_latency_80_83", ((s_ev_cyc - t3) >= 80 && (s_ev_cyc - t3) <= 83), 1);
        chk("slow_count", s_count, 1);
        run(120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
